// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch sequencer.
//   fetch_state_e : sequencer FSM states
//   INST_BYTES    : bytes per instruction word
//   PC_INC        : pc step after an accepted instruction
//   pc_legal()    : aligned and in-range check for a fetch PC
package fetch_pkg;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

    localparam int INST_BYTES = 4;
    localparam int PC_INC     = 4;

    // A fetch PC is legal when word aligned and the whole word lies inside
    // the ROM. A pc that wrapped past 2^ADDR_W lands far above the ROM, so
    // the range test also catches wrap.
    function automatic logic pc_legal(input logic [63:0] pc, input int mem_bytes);
        return (pc[1:0] == 2'b00) && (pc <= (64'(mem_bytes) - 64'(INST_BYTES)));
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: ROM read port, EX redirect, IF/ID handshake and fault.
//   master : the fetch sequencer side
//   slave  : ROM / EX / IF/ID side (testbench)
interface fetch_sequencer_if #(
    parameter int ADDR_W = 64
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              fault;

    modport master (
        output mem_rd, mem_addr, inst_valid, inst_data, inst_pc, fault,
        input  mem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_rd, mem_addr, inst_valid, inst_data, inst_pc, fault,
        output mem_rdata, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/inst_byte_assembler.sv
// inst_byte_assembler: 4-byte little-endian instruction buffer.
//   clk, reset_n : clock, async active-low reset
//   clr          : discard all buffered bytes
//   cap_en       : capture cap_byte into byte cap_idx this cycle
//   cap_idx      : byte lane being captured
//   cap_byte     : byte returned by the ROM
//   word         : {b3,b2,b1,b0}, with the byte being captured this cycle
//                  already merged in so the last byte needs no extra cycle
module inst_byte_assembler
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        cap_en,
    input  logic [1:0]  cap_idx,
    input  logic [7:0]  cap_byte,
    output logic [31:0] word
);
    logic [INST_BYTES-1:0][7:0] bytes_q;
    logic [INST_BYTES-1:0][7:0] bytes_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bytes_q <= '0;
        end else if (clr) begin
            bytes_q <= '0;
        end else begin
            for (int i = 0; i < INST_BYTES; i++) begin
                if (cap_en && (cap_idx == 2'(i))) bytes_q[i] <= cap_byte;
            end
        end
    end

    // Bypass so the final byte can be latched in the same cycle it arrives.
    always_comb begin
        bytes_c = bytes_q;
        if (cap_en && !clr) bytes_c[cap_idx] = cap_byte;
    end

    assign word = bytes_c;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: issues four byte reads per instruction to a byte-wide
// synchronous ROM, assembles the little-endian word and hands it to IF/ID.
//   clk, reset_n : clock, async active-low reset
//   bus          : fetch_sequencer_if.master
//     mem_rd/mem_addr/mem_rdata      ROM read port (data one cycle after rd)
//     redirect_valid/redirect_pc     taken branch from EX (highest priority)
//     inst_valid/inst_ready          IF/ID handshake for inst_data/inst_pc
//     fault                          misaligned or out-of-range fetch
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter int                MEM_BYTES = 208,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    fetch_sequencer_if.master  bus
);
    fetch_state_e      state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        cnt;
    logic              cap_en;
    logic [1:0]        cap_idx;
    logic [31:0]       asm_word;
    logic [31:0]       inst_data_q;
    logic [ADDR_W-1:0] inst_pc_q;
    logic              pc_ok;
    logic              issue;
    logic              inst_valid_c;
    logic              fault_c;
    logic              redirect;
    logic              handshake;

    assign redirect  = bus.redirect_valid;
    assign handshake = inst_valid_c & bus.inst_ready;
    assign pc_ok     = pc_legal(64'(pc), MEM_BYTES);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ISSUE;
        else          state <= state_nxt;
    end

    // Next state; a redirect overrides every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            ISSUE: begin
                if (cnt == 2'd0 && !pc_ok) state_nxt = FAULT;
                else if (cnt == 2'd3)      state_nxt = DRAIN;
            end
            DRAIN:   state_nxt = HOLD;
            HOLD:    if (handshake) state_nxt = ISSUE;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = ISSUE;
        endcase
        if (redirect) state_nxt = ISSUE;
    end

    // Outputs. Only the entry cycle (cnt=0) needs the legality check; later
    // issue cycles are reached only from a legal entry.
    always_comb begin
        issue        = 1'b0;
        inst_valid_c = 1'b0;
        fault_c      = 1'b0;
        case (state)
            ISSUE:   issue        = (cnt != 2'd0) || pc_ok;
            HOLD:    inst_valid_c = 1'b1;
            FAULT:   fault_c      = 1'b1;
            default: ;
        endcase
    end

    // The reset state is ISSUE at a legal pc, so the read strobe is gated
    // by reset_n to keep the ROM port quiet while reset is held.
    assign bus.mem_rd     = issue & reset_n;
    assign bus.mem_addr   = (issue & reset_n) ? (pc + ADDR_W'(cnt)) : '0;
    assign bus.inst_valid = inst_valid_c;
    assign bus.inst_data  = inst_data_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.fault      = fault_c;

    // pc, issue counter, capture tracking and the presented word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            cnt         <= 2'd0;
            cap_en      <= 1'b0;
            cap_idx     <= 2'd0;
            inst_data_q <= '0;
            inst_pc_q   <= '0;
        end else begin
            // The read issued in a redirect cycle returns into the new
            // fetch's first cycle; it must not land in the buffer.
            cap_en  <= issue & ~redirect;
            cap_idx <= cnt;
            if (redirect) begin
                pc  <= bus.redirect_pc;
                cnt <= 2'd0;
            end else begin
                if (issue)     cnt <= cnt + 2'd1;
                if (handshake) pc  <= pc + ADDR_W'(PC_INC);
                if (state == DRAIN) begin
                    inst_data_q <= asm_word;
                    inst_pc_q   <= pc;
                end
            end
        end
    end

    inst_byte_assembler u_asm (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (redirect),
        .cap_en   (cap_en),
        .cap_idx  (cap_idx),
        .cap_byte (bus.mem_rdata),
        .word     (asm_word)
    );
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus with a scoreboard. Stimulus pushes
// expected ROM read addresses and expected IF/ID words; a monitor pops and
// compares on every mem_rd and every inst_valid&inst_ready.
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_W(64)) bus();

    fetch_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [63:0] pc;
    } inst_t;

    logic [7:0]  rom [0:207];
    logic [63:0] addr_q [$];
    inst_t       inst_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;

    // Synchronous-read byte ROM.
    always @(posedge clk)
        if (bus.mem_rd)
            bus.mem_rdata <= (bus.mem_addr < 64'd208) ? rom[bus.mem_addr[7:0]] : 8'h00;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.mem_rd) begin
                if (addr_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL mem_rd_unexpected (cycle %0d): got addr %h, want no read", cyc, bus.mem_addr);
                end else begin
                    chk("mem_addr", bus.mem_addr, addr_q.pop_front());
                end
            end
            if (bus.inst_valid && bus.inst_ready) begin
                if (inst_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL inst_unexpected (cycle %0d): got %h@%h, want none", cyc, bus.inst_data, bus.inst_pc);
                end else begin
                    inst_t e;
                    e = inst_q.pop_front();
                    chk("inst_data", 64'(bus.inst_data), 64'(e.data));
                    chk("inst_pc", bus.inst_pc, e.pc);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
        bus.redirect_valid = 1'b0;
    endtask

    task automatic goto(input int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push_addrs(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) addr_q.push_back(base + 64'(i));
    endtask

    task automatic push_inst(input logic [31:0] d, input logic [63:0] p);
        inst_t e;
        e.data = d;
        e.pc   = p;
        inst_q.push_back(e);
    endtask

    task automatic redirect_to(input logic [63:0] p);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = p;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_rd"},     64'(bus.mem_rd),     64'd0);
        chk({tag, "_mem_addr"},   bus.mem_addr,        64'd0);
        chk({tag, "_inst_valid"}, 64'(bus.inst_valid), 64'd0);
        chk({tag, "_inst_data"},  64'(bus.inst_data),  64'd0);
        chk({tag, "_inst_pc"},    bus.inst_pc,         64'd0);
        chk({tag, "_fault"},      64'(bus.fault),      64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish before 100us");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 208; i++) rom[i] = 8'h00;
        // pc 0: 0x00000513, pc 4: 0x00100293, pc 8: 0x00000013
        rom[0]  = 8'h13; rom[1]  = 8'h05; rom[2]  = 8'h00; rom[3]  = 8'h00;
        rom[4]  = 8'h93; rom[5]  = 8'h02; rom[6]  = 8'h10; rom[7]  = 8'h00;
        rom[8]  = 8'h13; rom[9]  = 8'h00; rom[10] = 8'h00; rom[11] = 8'h00;
        // pc 0x50: 0x00a00093, pc 0x58: 0x00000293
        rom[80] = 8'h93; rom[81] = 8'h00; rom[82] = 8'ha0; rom[83] = 8'h00;
        rom[88] = 8'h93; rom[89] = 8'h02; rom[90] = 8'h00; rom[91] = 8'h00;

        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        sample();
        chk_all_zero("reset");

        // Basic fetch: 0..3, word at cycle 5, next fetch at 4 in cycle 6
        push_addrs(64'h0, 4); push_inst(32'h00000513, 64'h0);
        push_addrs(64'h4, 4); push_inst(32'h00100293, 64'h4);
        release_reset();
        sample();
        chk("c0_mem_rd", 64'(bus.mem_rd), 64'd1);
        goto(4); sample();
        chk("c4_inst_valid", 64'(bus.inst_valid), 64'd0);
        goto(5); sample();
        chk("c5_inst_valid", 64'(bus.inst_valid), 64'd1);
        goto(6);
        bus.inst_ready = 1'b0;
        sample();
        chk("c6_mem_rd", 64'(bus.mem_rd), 64'd1);
        chk("c6_mem_addr", bus.mem_addr, 64'h4);

        // Backpressure on the word at pc 4 for 10 cycles
        for (int c = 11; c <= 20; c++) begin
            goto(c); sample();
            chk("bp_valid", 64'(bus.inst_valid), 64'd1);
            chk("bp_data",  64'(bus.inst_data),  64'h00100293);
            chk("bp_pc",    bus.inst_pc,         64'h4);
            chk("bp_no_rd", 64'(bus.mem_rd),     64'd0);
        end
        goto(21);
        push_addrs(64'h8, 3);           // fetch of 8 is cut at cnt=2
        push_addrs(64'h58, 4); push_inst(32'h00000293, 64'h58);
        bus.inst_ready = 1'b1;
        goto(22);
        bus.inst_ready = 1'b0;
        sample();
        chk("c22_mem_addr", bus.mem_addr, 64'h8);

        // Redirect during the cnt=2 issue of pc 8
        goto(24);
        redirect_to(64'h58);
        goto(25); sample();
        chk("redir_mem_rd",    64'(bus.mem_rd),     64'd1);
        chk("redir_mem_addr",  bus.mem_addr,        64'h58);
        chk("redir_valid_low", 64'(bus.inst_valid), 64'd0);
        goto(29); sample();
        chk("c29_valid", 64'(bus.inst_valid), 64'd0);

        // Word 0x58 taken with a redirect to 0x50 in the same cycle
        goto(30);
        push_addrs(64'h50, 4); push_inst(32'h00a00093, 64'h50);
        bus.inst_ready = 1'b1;
        redirect_to(64'h50);
        goto(31); sample();
        chk("hs_redir_addr",  bus.mem_addr,        64'h50);
        chk("hs_redir_valid", 64'(bus.inst_valid), 64'd0);

        // Handshake at pc 0x50 coincident with redirect to 0x58
        goto(36);
        push_addrs(64'h58, 4); push_inst(32'h00000293, 64'h58);
        redirect_to(64'h58);
        goto(37); sample();
        chk("hs50_next_addr", bus.mem_addr, 64'h58);

        // Misaligned redirect target 0x52
        goto(42);
        redirect_to(64'h52);
        goto(43); sample();
        chk("mis_entry_rd",    64'(bus.mem_rd),     64'd0);
        chk("mis_entry_valid", 64'(bus.inst_valid), 64'd0);
        goto(44); sample();
        chk("mis_fault",    64'(bus.fault),      64'd1);
        chk("mis_no_rd",    64'(bus.mem_rd),     64'd0);
        chk("mis_no_valid", 64'(bus.inst_valid), 64'd0);
        goto(45); sample();
        chk("mis_fault_sticky", 64'(bus.fault), 64'd1);

        // Out-of-range redirect target 0xD0
        goto(46);
        redirect_to(64'hD0);
        goto(47); sample();
        chk("oor_entry_rd", 64'(bus.mem_rd), 64'd0);
        goto(48); sample();
        chk("oor_fault", 64'(bus.fault),  64'd1);
        chk("oor_no_rd", 64'(bus.mem_rd), 64'd0);

        // Recovery by redirect to 0
        goto(50);
        push_addrs(64'h0, 4);
        redirect_to(64'h0);
        goto(51); sample();
        chk("rec_fault", 64'(bus.fault),  64'd0);
        chk("rec_rd",    64'(bus.mem_rd), 64'd1);
        chk("rec_addr",  bus.mem_addr,    64'h0);

        // Async reset in the DRAIN cycle (cycle 55)
        goto(55);
        reset_n = 1'b0;
        #1;
        chk_all_zero("arst");
        repeat (2) @(posedge clk);

        // Restart from RESET_PC
        push_addrs(64'h0, 4); push_inst(32'h00000513, 64'h0);
        bus.inst_ready = 1'b1;
        release_reset();
        sample();
        chk("rst2_addr", bus.mem_addr, 64'h0);
        goto(5); sample();
        chk("rst2_valid", 64'(bus.inst_valid), 64'd1);
        goto(6);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("addr_q_empty", 64'(addr_q.size()), 64'd0);
        chk("inst_q_empty", 64'(inst_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequencer for the byte-wide, synchronous-read instruction ROM in the pipelined core. It holds the PC and issues four consecutive byte reads per instruction. It assembles them little-endian into a 32-bit word and presents it to the IF/ID register over a valid/ready handshake. It also handles branch redirects from EX and flags out-of-range or misaligned fetches.

## Interface
- ADDR_W, 64, PC and memory address width
- MEM_BYTES, 208, ROM size in bytes; legal fetch PCs are 0..MEM_BYTES-4
- RESET_PC, 0, PC loaded at reset
- clk  in  1  rising-edge clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- mem_rd  out  1  byte read strobe to ROM
- mem_addr  out  ADDR_W  byte address for the read
- mem_rdata  in  8  read data; valid exactly one cycle after the matching mem_rd
- redirect_valid  in  1  one-cycle pulse from EX: taken branch/jump
- redirect_pc  in  ADDR_W  new PC, sampled when redirect_valid=1
- inst_valid  out  1  inst_data/inst_pc valid
- inst_ready  in  1  IF/ID can accept
- inst_data  out  32  assembled instruction
- inst_pc  out  ADDR_W  PC of inst_data
- fault  out  1  sticky fetch fault (misaligned or out of range)

## Operation
- States: ISSUE, DRAIN, HOLD, FAULT. Registers: pc, issue counter cnt[1:0], capture counter, capture-enable bit, 4-byte assembly buffer.
- Reset: state=ISSUE, pc=RESET_PC, cnt=0, capture disabled. All outputs are 0 (mem_rd, mem_addr, inst_valid, inst_data, inst_pc, fault).
- ISSUE entry check (cnt=0): if pc[1:0]!=0 or pc>MEM_BYTES-4, go to FAULT with no mem_rd.
- ISSUE: mem_rd=1 and mem_addr=pc+cnt for cnt=0,1,2,3 on four consecutive cycles. After cnt=3, go to DRAIN.
- Capture: the byte returned for issue k is stored in buffer byte k, so inst_data = {b3,b2,b1,b0}.
- DRAIN: capture b3, latch inst_data and inst_pc=pc, set inst_valid, go to HOLD.
- HOLD: inst_valid stays 1 and inst_data/inst_pc stay stable until inst_valid & inst_ready. On that handshake: pc=pc+4, inst_valid=0, state=ISSUE with cnt=0.
- FAULT: fault=1, inst_valid=0, mem_rd=0. Only a redirect or reset leaves FAULT.
- Redirect has the highest priority in every state. Next cycle: pc=redirect_pc, state=ISSUE, cnt=0, inst_valid=0, fault=0, buffer contents discarded.
- The read in flight when the redirect arrives returns one cycle later and must not be captured. The capture-enable bit is cleared for that cycle.
- Redirect coincident with an inst_valid&inst_ready handshake: the handshake completes (IF/ID takes the word), and pc takes redirect_pc, not pc+4.
- A redirect to a bad target enters ISSUE, then FAULT on the entry check.
- pc arithmetic is modulo 2^ADDR_W; wrap is caught by the range check.
- inst_ready while inst_valid=0 is ignored.

## Timing
- A fetch starts in cycle T, the first ISSUE cycle.
- mem_rd is high in T..T+3 with addresses pc..pc+3.
- Bytes b0..b3 arrive in T+1..T+4; T+4 is the DRAIN cycle.
- inst_valid is first high in T+5, giving a latency of 5 cycles.
- With inst_ready held at 1, the handshake happens in T+5 and the next ISSUE starts in T+6: one instruction per 6 cycles.
- After reset release, the first mem_rd is in the first clock cycle, and the first inst_valid follows 5 cycles later.
- Redirect sampled at edge E: mem_rd for redirect_pc is driven in the cycle after E, and inst_valid is 0 in that cycle.
- The FAULT decision is made in the ISSUE entry cycle, so fault is high from the next cycle.
- Asynchronous reset mid-fetch: all outputs drop to 0 immediately and no partial instruction is ever presented.

## Structure
- Shared package fetch_pkg holds:
  - the state enum (ISSUE, DRAIN, HOLD, FAULT)
  - INST_BYTES=4 and the PC increment constant 4
  - the legal-PC check as a function parameterized by MEM_BYTES
- One sub-module, inst_byte_assembler: a 4-byte buffer with capture enable, byte index and clear, outputting the {b3,b2,b1,b0} word.
- The FSM, pc and redirect logic stay in fetch_sequencer.

## Test plan
- Reset, ROM bytes 0..3 = 13 05 00 00, inst_ready=1:
  - mem_rd addresses 0,1,2,3 in cycles 0..3
  - inst_valid in cycle 5 with inst_data=32'h00000513, inst_pc=0
  - next fetch at address 4 in cycle 6
- Backpressure: inst_ready=0 for 10 cycles with the word at pc=4 (32'h00100293) presented. inst_valid, inst_data and inst_pc stay stable and there is no mem_rd. Raising inst_ready gives the handshake, and fetch of 8 begins the next cycle.
- Redirect mid-ISSUE (cnt=2) to 0x58: the stale byte is not captured, the next addresses are 0x58..0x5B, and inst_data=32'h00000293.
- Redirect coincident with a handshake at pc=0x50, target 0x58: the word is accepted once, and the next fetch is at 0x58, not 0x54.
- Redirect to 0x52 (misaligned) or 0xD0 (>204): no mem_rd, fault=1 and inst_valid=0 from the next cycle. A later redirect to 0 clears fault and fetch resumes.
- Assert reset_n=0 during DRAIN: outputs go to 0 immediately, and after release fetch restarts at RESET_PC.
